// File: rtl/cpu_pkg.sv
// cpu_pkg: shared fetch-stage types and constants (also used by the PC register)
package cpu_pkg;
    localparam int PC_W = 16;
    localparam int INSTR_BYTES = 2;
    localparam logic [PC_W-1:0] RESET_PC = 16'h0000;
    typedef enum logic [1:0] {S_REQ, S_WAIT, S_HALT} fetch_state_t;
endpackage

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: next-PC sequencing, single-outstanding imem requests and a 1-entry decode buffer
module fetch_ctrl
    import cpu_pkg::*;
#(
    parameter int INSTR_BYTES = cpu_pkg::INSTR_BYTES,
    parameter int PC_W        = cpu_pkg::PC_W
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [PC_W-1:0] pc,
    output logic [PC_W-1:0] pc_next,
    output logic            imem_req,
    output logic [PC_W-1:0] imem_addr,
    input  logic            imem_ready,
    input  logic            imem_rvalid,
    input  logic [15:0]     imem_rdata,
    output logic            instr_valid,
    output logic [15:0]     instr,
    output logic [PC_W-1:0] instr_pc,
    input  logic            dec_ready,
    input  logic            redirect,
    input  logic [PC_W-1:0] redirect_pc,
    input  logic            halt_in,
    output logic            halted
);
    fetch_state_t    state, state_d;
    logic            squash, squash_d, halted_d, accept, load, flush, valid_d;
    logic [PC_W-1:0] req_pc;

    // issue only when the buffer is free or draining; redirect beats accept, which beats hold
    always_comb begin
        imem_req  = state == S_REQ && !redirect && !halt_in && (!instr_valid || dec_ready);
        accept    = imem_req && imem_ready;
        imem_addr = pc;
        pc_next   = (redirect && state != S_HALT) ? (redirect_pc & ~PC_W'(1))
                  : accept ? pc + PC_W'(INSTR_BYTES) : pc;
    end

    // next state: redirect outranks halt (a HLT beside a redirect is wrong-path), halt outranks responses
    always_comb begin
        state_d  = state;
        squash_d = squash;
        halted_d = halted;
        load     = 1'b0;
        flush    = 1'b0;
        if (state != S_HALT) begin
            if (redirect) begin
                flush    = 1'b1;
                squash_d = state == S_WAIT && !imem_rvalid;
                state_d  = squash_d ? S_WAIT : S_REQ;
            end else if (halt_in) begin
                flush    = 1'b1;
                squash_d = 1'b0;
                halted_d = 1'b1;
                state_d  = S_HALT;
            end else if (state == S_WAIT && imem_rvalid) begin
                load     = !squash;
                squash_d = 1'b0;
                state_d  = S_REQ;
            end else if (accept) begin
                state_d = S_WAIT;
            end
        end
        valid_d = load || (instr_valid && !flush && !dec_ready);
    end

    // control state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= S_REQ;
            squash <= 1'b0;
            halted <= 1'b0;
        end else begin
            state  <= state_d;
            squash <= squash_d;
            halted <= halted_d;
        end
    end

    // decode buffer and the address of the request in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr_valid <= 1'b0;
            instr       <= '0;
            instr_pc    <= RESET_PC;
            req_pc      <= RESET_PC;
        end else begin
            instr_valid <= valid_d;
            if (load) begin
                instr    <= imem_rdata;
                instr_pc <= req_pc;
            end
            if (accept)
                req_pc <= pc;
        end
    end
endmodule
